alu_reservation_station: RTL
============================

ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of instruction entries; legal values are 2..8.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flash  input  1  synchronous pipeline flush.
REQ-005 SHALL have port in_en  input  1  AluInstr offered by decode.
REQ-006 SHALL have port in_msg  input  AluInstr  offered instruction: commit_id, aux_op, funct3, dest_logic, dest_phys, src1, src2.
REQ-007 SHALL have port in_reject  output  1  offer not taken; decode holds and re-presents it.
REQ-008 SHALL have port cdb_en  input  1  completion broadcast valid.
REQ-009 SHALL have port cdb_tag  input  64  one-hot physical tag of the completing result.
REQ-010 SHALL have port cdb_data  input  32  completing result value.
REQ-011 SHALL have port out_en  output  1  ready instruction presented to the ALU.
REQ-012 SHALL have port out_msg  output  AluInstr  issued instruction; src1 and src2 both have valid=1.
REQ-013 SHALL have port out_reject  input  1  ALU did not take out_msg this cycle.

Function
REQ-014 SHALL hold entries in an age-ordered queue, slot 0 oldest, compacted on every removal.
REQ-015 SHALL drive in_reject = 1 exactly when all DEPTH slots are occupied at cycle start, with no same-cycle bypass of a freeing issue.
REQ-016 SHALL write in_msg into the lowest free slot when in_en=1, in_reject=0 and flash=0.
REQ-017 SHALL, for every stored or incoming source with valid=0, set valid=1 and data=cdb_data when cdb_en=1 and (tag AND cdb_tag) is nonzero; sources with valid=1 are never changed.
REQ-018 SHALL mark an entry ready when both sources are valid in registered state; a wakeup or acceptance in cycle N can make the entry issuable no earlier than cycle N+1.
REQ-019 SHALL assert out_en when any registered entry is ready and flash=0, presenting the oldest ready entry on out_msg.
REQ-020 SHALL remove the presented entry at the clock edge when out_en=1 and out_reject=0.
REQ-021 SHALL keep out_msg bit-identical and out_en=1 across cycles while out_reject=1, even if an older entry becomes ready; reselection happens only after acceptance or flash.
REQ-022 SHALL, when acceptance and issue occur in the same cycle, perform both, with compaction applied before the new entry is placed.
REQ-023 SHALL, when flash=1, drive out_en=0, ignore in_en, invalidate every entry at the edge, and release any held selection.
REQ-024 SHALL give an entry minimum latency of 1 cycle from acceptance to out_en when both sources arrive valid.
REQ-025 SHALL never issue one entry twice and never lose an accepted, unflushed entry.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously clear all entry-valid bits, the held selection and the occupancy count.
REQ-027 SHALL hold in_reject=0 and out_en=0 while reset_n=0.
REQ-028 SHALL, when reset asserts mid-operation, discard all stored instructions without issuing them.
REQ-029 SHALL make the first acceptance possible at the first rising edge after reset_n deasserts.

Verification
REQ-030 SHALL cover operand-ready issue: accept an instruction with both sources valid (commit_id=3) at cycle 0 -> out_en=1 with commit_id=3 at cycle 1, then empty.
REQ-031 SHALL cover wakeup: store src1 pending on tag bit 5, then broadcast cdb_tag=1<<5, cdb_data=0xDEADBEEF -> next cycle out_msg.src1.data=0xDEADBEEF, valid=1.
REQ-032 SHALL cover full: fill 4 entries with pending sources and offer a fifth -> in_reject=1; issue one -> the fifth is accepted one cycle later.
REQ-033 SHALL cover hold: set out_reject=1 for 3 cycles while an older entry wakes -> out_msg unchanged for all 3 cycles, then the older entry issues after acceptance.
REQ-034 SHALL cover flash: flash with 3 entries stored and out_en=1 -> out_en=0 that cycle and queue empty next cycle.
REQ-035 SHALL cover reset: assert reset_n=0 mid-stream -> out_en=0 and in_reject=0 immediately, with no stale issue after release.

Source files
------------

// File: rtl/alu_reservation_station.sv
// Age-ordered ALU reservation station: compacted queue (slot 0 oldest), CDB operand wakeup,
// oldest-ready issue with a held selection while the ALU stalls.
module alu_reservation_station #(
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flash,
    input  logic         in_en,
    input  logic [216:0] in_msg,
    output logic         in_reject,
    input  logic         cdb_en,
    input  logic [63:0]  cdb_tag,
    input  logic [31:0]  cdb_data,
    output logic         out_en,
    output logic [216:0] out_msg,
    input  logic         out_reject
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic        valid;
        logic [63:0] tag;
        logic [31:0] data;
    } src_t;

    typedef struct packed {
        logic [7:0] commit_id;
        logic       aux_op;
        logic [2:0] funct3;
        logic [4:0] dest_logic;
        logic [5:0] dest_phys;
        src_t       src1;
        src_t       src2;
    } instr_t;

    function automatic src_t wake_src(src_t s, logic en, logic [63:0] tag, logic [31:0] data);
        src_t r;
        r = s;
        if (!s.valid && en && |(s.tag & tag)) begin
            r.valid = 1'b1;
            r.data  = data;
        end
        return r;
    endfunction

    function automatic instr_t wake_instr(instr_t x, logic en, logic [63:0] tag, logic [31:0] data);
        instr_t r;
        r      = x;
        r.src1 = wake_src(x.src1, en, tag, data);
        r.src2 = wake_src(x.src2, en, tag, data);
        return r;
    endfunction

    instr_t           entries   [DEPTH];
    instr_t           entries_n [DEPTH];
    logic [CW-1:0]    count, count_n, count_mid;
    logic [CW-1:0]    sel, hold_idx;
    logic             hold_valid, hold_valid_n;
    logic             any_ready, issue, accept;
    logic [DEPTH-1:0] ready;

    // Readiness only looks at registered operands, so a wakeup can issue no earlier than next cycle.
    always_comb begin
        ready     = '0;
        any_ready = 1'b0;
        sel       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = (CW'(i) < count) && entries[i].src1.valid && entries[i].src2.valid;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                any_ready = 1'b1;
                sel       = CW'(i);
            end
        end
        if (hold_valid) begin
            sel = hold_idx;
        end
    end

    always_comb begin
        out_en    = (hold_valid || any_ready) && !flash;
        in_reject = (count == CW'(DEPTH));
        issue     = out_en && !out_reject;
        accept    = in_en && !in_reject && !flash;
        out_msg   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == sel) begin
                out_msg = entries[i];
            end
        end
    end

    // Removal compacts the queue first; the new entry then lands in the first free slot.
    always_comb begin
        count_mid    = issue ? count - CW'(1) : count;
        count_n      = flash ? '0 : count_mid + CW'(accept);
        hold_valid_n = out_en && out_reject;
        for (int i = 0; i < DEPTH; i++) begin
            int j;
            j = (issue && (CW'(i) >= sel) && (i < DEPTH - 1)) ? i + 1 : i;
            entries_n[i] = wake_instr(entries[j], cdb_en, cdb_tag, cdb_data);
            if (accept && (CW'(i) == count_mid)) begin
                entries_n[i] = wake_instr(instr_t'(in_msg), cdb_en, cdb_tag, cdb_data);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            hold_valid <= 1'b0;
            hold_idx   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            count      <= count_n;
            hold_valid <= hold_valid_n;
            hold_idx   <= sel;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= entries_n[i];
            end
        end
    end

endmodule
